dmem_responder: RTL
===================

# dmem_responder

Multi-cycle data-memory responder that sits on the far side of the pipeline's MEM-stage load/store port. It accepts one read or write request at a time through a valid/ready handshake. It completes the request after a fixed latency and returns a one-cycle response pulse. While the request is outstanding it drives a stall that freezes the upstream pipeline registers.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two ≥ 4.
- LATENCY, 3: cycles from request acceptance to response; ≥ 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  MEM stage presents a request (MemRead or MemWrite asserted)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data
- req_ready  out  1  responder can accept a request this cycle
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  32  load data; valid with resp_valid, held until next response
- resp_err  out  1  misaligned access flag, qualified by resp_valid
- stall  out  1  freeze PC, IF_ID, ID_EX and EX_MEM this cycle

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE
  - req_ready = 1.
  - If req_valid, latch req_write, req_addr and req_wdata, and load cnt = LATENCY-1.
  - Next state is WAIT, or DONE if LATENCY == 1.
- WAIT
  - req_ready = 0; cnt decrements each cycle.
  - When cnt == 1, commit the access at that edge and go to DONE.
- Commit edge
  - Store: write the latched data to the array.
  - Load: capture the array word into resp_rdata.
- DONE
  - resp_valid = 1, req_ready = 0.
  - Next state is IDLE unconditionally.
- stall = req_valid & ~resp_valid (combinational).
- Word index is req_addr[2 +: log2(DEPTH_WORDS)]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Latched request fields are used exclusively after acceptance. Changes on req_* or dropping req_valid in WAIT or DONE have no effect.
- A store does not modify resp_rdata. resp_rdata keeps the last load value.
- A load from a never-written word returns the array's uninitialised content. The bench must not rely on it.

## Timing
- Request is accepted at edge T (req_valid & req_ready). resp_valid is high during cycle T+LATENCY. The responder is back in IDLE in cycle T+LATENCY+1.
- Maximum throughput is one request per LATENCY+1 cycles.
- A load issued after a store to the same word returns the stored value. There is no hazard window because requests are serialized.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, cnt 0. The array is not cleared.
- Reset during WAIT or DONE:
  - The pending access is dropped; a store not yet committed is never written.
  - The responder is in IDLE the cycle after rst deasserts.
- stall in DONE is 0, so the pipeline advances on the same edge that leaves DONE. A new request presented in the following IDLE cycle is accepted immediately.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - req_addr[1:0] != 0 is flagged misaligned. The request is accepted and timed normally.
  - A misaligned store is suppressed.
  - A misaligned load returns resp_rdata = 0.
  - resp_err = 1 during the DONE cycle.
- DMEM_ALIGN_CHECK_EN undefined: req_addr[1:0] is ignored and resp_err is tied 0.

## Structure
- Shared package mips_pkg holds:
  - the state enum (IDLE/WAIT/DONE);
  - default DEPTH_WORDS and LATENCY constants;
  - the word width constant (32).
- One sub-module, dmem_array: single-port synchronous RAM, DEPTH_WORDS x 32, with write enable and registered read. It has no reset.
- The FSM, counter, request latches and alignment check live in dmem_responder.

## Test plan
- Store/load, LATENCY=3:
  - Store 0xDEADBEEF to 0x10 at edge 0: resp_valid in cycle 3, stall high in cycles 0–2.
  - Load 0x10 at cycle 4: resp_rdata = 0xDEADBEEF in cycle 7.
- Wrap, DEPTH_WORDS=256: store 0x12345678 to 0x400, then load 0x000 → 0x12345678.
- Request change after acceptance: after acceptance, change req_addr and req_wdata and drop req_valid in WAIT → the original transaction completes and the target word holds the original data.
- Reset mid-op:
  - Store 0xAAAA5555 to 0x20 over prior value 0x11111111, with rst in cycle 1 → no resp_valid, and state is IDLE after reset.
  - A subsequent load of 0x20 returns 0x11111111.
- LATENCY=1 back-to-back: two consecutive loads → resp_valid in cycles 1 and 3; req_ready is 0 only in cycles 1 and 3.
- DMEM_ALIGN_CHECK_EN, misaligned store:
  - Store 0xCAFEF00D to 0x22 over prior 0x0 → resp_err = 1 with resp_valid.
  - A load of 0x20 returns 0x0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and FSM state type for the data-memory responder.
// Word width, default geometry and default access latency live here.
package mips_pkg;

    localparam int WORD_W          = 32;
    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_LATENCY     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, write-enable plus registered read.
// Read data only changes on an enabled read, so it holds between loads; no reset.
module dmem_array
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder with valid/ready request, one-cycle response and pipeline stall.
// Optional misalignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    state_t state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              lat_write;
    logic [AW-1:0]     lat_idx;
    logic [WORD_W-1:0] lat_wdata;
    logic              lat_mis;
    logic              rd_sel;
    logic              err_q;
    logic [WORD_W-1:0] arr_rdata;

    logic              accept;
    logic              commit;
    logic              live;
    logic              mis_now;
    logic              c_write;
    logic [AW-1:0]     c_idx;
    logic [WORD_W-1:0] c_wdata;
    logic              c_mis;
    logic              unused_addr;

    assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis_now  = (req_addr[1:0] != 2'b00);
    assign resp_err = (state == DONE) & err_q;
`else
    assign mis_now  = 1'b0;
    assign resp_err = 1'b0;
`endif

    assign accept = (state == IDLE) & req_valid;

    // With LATENCY==1 the access commits on the acceptance edge, so it must use the live request.
    assign live    = (state == IDLE);
    assign commit  = ((LATENCY == 1) && accept) || ((state == WAIT) && (cnt == CW'(1)));
    assign c_write = live ? req_write : lat_write;
    assign c_idx   = live ? req_addr[2 +: AW] : lat_idx;
    assign c_wdata = live ? req_wdata : lat_wdata;
    assign c_mis   = live ? mis_now : lat_mis;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .en    (commit & ~c_mis),
        .we    (c_write),
        .addr  (c_idx),
        .wdata (c_wdata),
        .rdata (arr_rdata)
    );

    // The array has no reset, so a select flag supplies the zero after reset and for misaligned loads.
    assign resp_rdata = rd_sel ? arr_rdata : '0;
    assign stall      = req_valid & ~resp_valid;

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rd_sel <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= CNT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - CW'(1);
            end
            if (commit) begin
                err_q <= c_mis;
                if (!c_write) begin
                    rd_sel <= ~c_mis;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_idx   <= req_addr[2 +: AW];
            lat_wdata <= req_wdata;
            lat_mis   <= mis_now;
        end
    end

endmodule
